shift_reg_pair: RTL and testbench

- Parametrised successor to the fixed 8-bit A/B shift-register pair used by the multiplier datapath.
- Holds two WIDTH-bit registers, A (upper) and B (lower), that shift as one 2*WIDTH-bit concatenation {A,B}.
- Adds selectable shift modes and an autonomous burst mode: a single Start shifts N times with Busy/Done handshake, removing the per-bit shift sequencing from the control FSM.

---
 rtl/shift_reg_pair.sv | 158 +++++++++++++++
 tb/tb_shift_reg_pair.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_pair.sv
// rtl/shift_reg_pair.sv - paired A/B shift registers with single-step and burst shifting
module shift_reg_pair #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(2*WIDTH+1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             Ld_A,
  input  logic             Ld_B,
  input  logic             Clr_A,
  input  logic             Shift_En,
  input  logic [1:0]       Mode,
  input  logic             Shift_In,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             A_out,
  output logic             B_out,
  output logic             Busy,
  output logic             Done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // Longest useful burst: every bit of {A,B} shifted out once.
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2*WIDTH);

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [1:0]       mode_sel;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [CNT_W-1:0] count_sat;
  logic             idle_start;
  logic             idle_load;
  logic             idle_shift;

  // A burst must keep the mode captured at Start; single steps follow the live Mode.
  assign mode_sel   = (state == ST_BURST) ? mode_q : Mode;
  assign count_sat  = (Count > MAX_CNT) ? MAX_CNT : Count;
  assign idle_start = (state == ST_IDLE) && Start;
  assign idle_load  = (state == ST_IDLE) && !Start && (Clr_A || Ld_A || Ld_B);
  assign idle_shift = (state == ST_IDLE) && !Start && !(Clr_A || Ld_A || Ld_B) && Shift_En;

  // One step of the {A,B} concatenation in the selected mode.
  always_comb begin
    shift_a = a_q;
    shift_b = b_q;
    case (mode_sel)
      MODE_LSR: begin
        shift_a = {Shift_In, a_q[WIDTH-1:1]};
        shift_b = {a_q[0], b_q[WIDTH-1:1]};
      end
      MODE_ASR: begin
        shift_a = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        shift_b = {a_q[0], b_q[WIDTH-1:1]};
      end
      MODE_LSL: begin
        shift_a = {a_q[WIDTH-2:0], b_q[WIDTH-1]};
        shift_b = {b_q[WIDTH-2:0], Shift_In};
      end
      MODE_ROR: begin
        shift_a = {b_q[0], a_q[WIDTH-1:1]};
        shift_b = {a_q[0], b_q[WIDTH-1:1]};
      end
      default: begin
        shift_a = a_q;
        shift_b = b_q;
      end
    endcase
  end

  // Burst sequencer: IDLE -> BURST for the saturated count -> one DONE cycle -> IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      mode_q    <= MODE_LSR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (Count == '0) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_BURST;
              remaining <= count_sat;
              mode_q    <= Mode;
            end
          end
        end
        ST_BURST: begin
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          remaining <= '0;
        end
      endcase
    end
  end

  // Register A: clear beats load; any load/clear blocks the single-step shift.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q <= '0;
    end else if (state == ST_BURST || idle_shift) begin
      a_q <= shift_a;
    end else if (idle_load) begin
      if (Clr_A) begin
        a_q <= '0;
      end else if (Ld_A) begin
        a_q <= D;
      end
    end
  end

  // Register B: load is independent of A's clear/load.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      b_q <= '0;
    end else if (state == ST_BURST || idle_shift) begin
      b_q <= shift_b;
    end else if (idle_load && Ld_B) begin
      b_q <= D;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign A_out = a_q[0];
  assign B_out = b_q[0];
  assign Busy  = (state == ST_BURST);
  assign Done  = (state == ST_DONE);

  logic unused_start_path;
  assign unused_start_path = idle_start;

endmodule

// File: tb/tb_shift_reg_pair.sv
// tb/tb_shift_reg_pair.sv - randomized and directed checks of shift_reg_pair against a bench model
module tb_shift_reg_pair;

  localparam int W = 8;
  localparam int CW = $clog2(2*W+1);

  logic          Clk, Reset;
  logic [W-1:0]  D;
  logic          Ld_A, Ld_B, Clr_A, Shift_En, Shift_In, Start;
  logic [1:0]    Mode;
  logic [CW-1:0] Count;
  logic [W-1:0]  A, B;
  logic          A_out, B_out, Busy, Done;

  int checks = 0;
  int failures = 0;
  int busy_cycles = 0;
  int done_cycles = 0;

  shift_reg_pair #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .D(D), .Ld_A(Ld_A), .Ld_B(Ld_B), .Clr_A(Clr_A),
    .Shift_En(Shift_En), .Mode(Mode), .Shift_In(Shift_In), .Start(Start),
    .Count(Count), .A(A), .B(B), .A_out(A_out), .B_out(B_out), .Busy(Busy), .Done(Done)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // Model: {A,B} held as one 16-bit value, burst tracked as shifts left to do.
  logic [2*W-1:0] m_ab;
  int             m_left;
  bit             m_done;
  logic [1:0]     m_mode;

  function automatic logic [2*W-1:0] step(input logic [2*W-1:0] v, input logic [1:0] m, input logic si);
    case (m)
      2'b00:   return {si, v[2*W-1:1]};
      2'b01:   return {v[2*W-1], v[2*W-1:1]};
      2'b10:   return {v[2*W-2:0], si};
      default: return {v[0], v[2*W-1:1]};
    endcase
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_ab = '0; m_left = 0; m_done = 0; m_mode = 2'b00;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_ab = step(m_ab, m_mode, Shift_In);
      m_left = m_left - 1;
      if (m_left == 0) m_done = 1;
    end else if (Start) begin
      if (Count == 0) m_done = 1;
      else begin
        m_left = (int'(Count) > 2*W) ? 2*W : int'(Count);
        m_mode = Mode;
      end
    end else if (Clr_A || Ld_A || Ld_B) begin
      if (Clr_A) m_ab[2*W-1:W] = '0;
      else if (Ld_A) m_ab[2*W-1:W] = D;
      if (Ld_B) m_ab[W-1:0] = D;
    end else if (Shift_En) begin
      m_ab = step(m_ab, Mode, Shift_In);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus busy/done pulse counting.
  always @(negedge Clk) begin
    check("A", 32'(A), 32'(m_ab[2*W-1:W]));
    check("B", 32'(B), 32'(m_ab[W-1:0]));
    check("A_out", 32'(A_out), 32'(m_ab[W]));
    check("B_out", 32'(B_out), 32'(m_ab[0]));
    check("Busy", 32'(Busy), 32'(m_left > 0));
    check("Done", 32'(Done), 32'(m_done));
    if (Busy) busy_cycles++;
    if (Done) done_cycles++;
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic clear_inputs();
    D = '0; Ld_A = 0; Ld_B = 0; Clr_A = 0; Shift_En = 0;
    Mode = 2'b00; Shift_In = 0; Start = 0; Count = '0;
  endtask

  task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
    clear_inputs(); Ld_A = 1; D = a; tick();
    clear_inputs(); Ld_B = 1; D = b; tick();
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    Reset = 1;
    tick(); tick();
    check("reset_A", 32'(A), 32'h00);
    check("reset_Busy", 32'(Busy), 32'h0);
    Reset = 0;

    // Asynchronous reset mid-cycle
    clear_inputs(); Ld_A = 1; Ld_B = 1; D = 8'h5A; tick(); clear_inputs();
    check("pre_async_A", 32'(A), 32'h5A);
    Reset = 1; #1;
    check("async_A", 32'(A), 32'h00);
    check("async_B", 32'(B), 32'h00);
    check("async_Busy", 32'(Busy), 32'h0);
    check("async_Done", 32'(Done), 32'h0);
    tick(); Reset = 0;

    // Loads and arithmetic step
    Ld_A = 1; Ld_B = 1; D = 8'hB5; tick(); clear_inputs();
    check("ldab_A", 32'(A), 32'hB5);
    check("ldab_B", 32'(B), 32'hB5);
    Ld_B = 1; D = 8'h3C; tick(); clear_inputs();
    Shift_En = 1; Mode = 2'b01; tick(); clear_inputs();
    check("asr_A", 32'(A), 32'hDA);
    check("asr_B", 32'(B), 32'h9E);
    check("asr_A_out", 32'(A_out), 32'h0);
    check("asr_B_out", 32'(B_out), 32'h0);

    // Burst of 8, junk inputs during burst and DONE
    load_ab(8'h01, 8'h00);
    busy_cycles = 0; done_cycles = 0;
    Mode = 2'b00; Shift_In = 0; Start = 1; Count = CW'(8); tick();
    Mode = 2'b10; Ld_A = 1; D = 8'hAA; Start = 1; Count = CW'(3);
    repeat (8) tick();
    check("burst_Done", 32'(Done), 32'h1);
    check("burst_A", 32'(A), 32'h00);
    check("burst_B", 32'(B), 32'h01);
    tick(); clear_inputs();
    check("burst_busy_cycles", 32'(busy_cycles), 32'd8);
    check("burst_done_cycles", 32'(done_cycles), 32'd1);

    // Rotate then left
    load_ab(8'h80, 8'h01);
    Mode = 2'b11; Shift_En = 1; tick(); clear_inputs();
    check("ror_A", 32'(A), 32'hC0);
    check("ror_B", 32'(B), 32'h00);
    Mode = 2'b10; Shift_In = 1; Shift_En = 1; tick(); clear_inputs();
    check("lsl_A", 32'(A), 32'h80);
    check("lsl_B", 32'(B), 32'h01);

    // Count = 0
    busy_cycles = 0; done_cycles = 0;
    Start = 1; Count = '0; tick(); clear_inputs();
    check("cnt0_Done", 32'(Done), 32'h1);
    check("cnt0_A", 32'(A), 32'h80);
    check("cnt0_B", 32'(B), 32'h01);
    tick();
    check("cnt0_busy_cycles", 32'(busy_cycles), 32'd0);
    check("cnt0_done_cycles", 32'(done_cycles), 32'd1);

    // Count = 20 saturates to 16
    busy_cycles = 0; done_cycles = 0;
    Mode = 2'b11; Start = 1; Count = CW'(20); tick(); clear_inputs();
    repeat (20) tick();
    check("sat_busy_cycles", 32'(busy_cycles), 32'd16);
    check("sat_done_cycles", 32'(done_cycles), 32'd1);
    check("sat_A", 32'(A), 32'h80);
    check("sat_B", 32'(B), 32'h01);

    // Clear beats load
    Clr_A = 1; Ld_A = 1; D = 8'hFF; tick(); clear_inputs();
    check("clr_ld_A", 32'(A), 32'h00);
    check("clr_ld_B", 32'(B), 32'h01);

    // Reset during burst
    load_ab(8'h01, 8'h00);
    busy_cycles = 0; done_cycles = 0;
    Start = 1; Count = CW'(8); tick(); clear_inputs();
    tick(); tick();
    Reset = 1; #1;
    check("abort_A", 32'(A), 32'h00);
    check("abort_B", 32'(B), 32'h00);
    check("abort_Busy", 32'(Busy), 32'h0);
    tick(); Reset = 0;
    repeat (10) tick();
    check("abort_done_cycles", 32'(done_cycles), 32'd0);
    busy_cycles = 0; done_cycles = 0;
    load_ab(8'hC3, 8'h00);
    Mode = 2'b00; Shift_In = 1; Start = 1; Count = CW'(2); tick(); Start = 0;
    repeat (3) tick(); clear_inputs();
    check("post_abort_busy", 32'(busy_cycles), 32'd2);
    check("post_abort_done", 32'(done_cycles), 32'd1);
    check("post_abort_A", 32'(A), 32'hF0);
    check("post_abort_B", 32'(B), 32'hC0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      D        = W'($urandom);
      Ld_A     = ($urandom_range(0, 5) == 0);
      Ld_B     = ($urandom_range(0, 5) == 0);
      Clr_A    = ($urandom_range(0, 7) == 0);
      Shift_En = $urandom_range(0, 1) == 1;
      Mode     = 2'($urandom);
      Shift_In = $urandom_range(0, 1) == 1;
      Start    = ($urandom_range(0, 15) == 0);
      Count    = CW'($urandom_range(0, 31));
      Reset    = ($urandom_range(0, 99) == 0);
      tick();
    end
    Reset = 0;
    clear_inputs();
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
